// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising checker for the 8-bit Fibonacci LFSR stream; define LFSR_CHK_BITERR_EN to build the bit-error counter
module lfsr_checker #(
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 3,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err,
   output logic             lost,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_err_count
);
   typedef enum logic {HUNT, LOCKED} state_t;
   localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
   localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);
   function automatic logic [7:0] nxt(input logic [7:0] s);
      return {s[6:0], s[0] ^ s[3] ^ s[5] ^ s[6]};
   endfunction
   state_t           state, state_n;
   logic             seed, seed_n, err_n, lost_n, hit, miss;
   logic [7:0]       exp_q, exp_n;
   logic [3:0]       match_cnt, match_n, miss_cnt, miss_n;
   logic [CNT_W-1:0] err_base, err_cnt_n;
   assign hit      = in_data == exp_q;
   assign miss     = in_valid && state == LOCKED && !hit;
   assign err_base = clr_cnt ? '0 : err_count;
   assign err_cnt_n = (miss && ~&err_base) ? err_base + 1'b1 : err_base;
   // next-state: seed/track in HUNT, free-running prediction in LOCKED
   always_comb begin
      state_n = state;
      seed_n  = seed;
      exp_n   = exp_q;
      match_n = match_cnt;
      miss_n  = miss_cnt;
      err_n   = 1'b0;
      lost_n  = 1'b0;
      if (in_valid) begin
         if (state == LOCKED) begin
            exp_n  = nxt(exp_q);
            miss_n = hit ? 4'd0 : miss_cnt + 4'd1;
            err_n  = !hit;
            if (!hit && miss_cnt + 4'd1 == LOSS_N) begin
               state_n = HUNT;
               seed_n  = 1'b0;
               lost_n  = 1'b1;
            end
         end else if (seed && hit) begin
            match_n = match_cnt + 4'd1;
            exp_n   = nxt(in_data);
            if (match_cnt + 4'd1 == LOCK_N) begin
               state_n = LOCKED;
               miss_n  = 4'd0;
            end
         end else begin
            seed_n  = in_data != 8'h00;
            exp_n   = in_data != 8'h00 ? nxt(in_data) : exp_q;
            match_n = 4'd0;
         end
      end
   end
   // state, prediction and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= HUNT;
         seed      <= 1'b0;
         exp_q     <= 8'h00;
         match_cnt <= 4'd0;
         miss_cnt  <= 4'd0;
         locked    <= 1'b0;
         err       <= 1'b0;
         lost      <= 1'b0;
         err_count <= '0;
      end else begin
         state     <= state_n;
         seed      <= seed_n;
         exp_q     <= exp_n;
         match_cnt <= match_n;
         miss_cnt  <= miss_n;
         locked    <= state_n == LOCKED;
         err       <= err_n;
         lost      <= lost_n;
         err_count <= err_cnt_n;
      end
   end
`ifdef LFSR_CHK_BITERR_EN
   logic [3:0]       pop;
   logic [CNT_W-1:0] bit_base;
   logic [CNT_W:0]   bit_sum;
   assign pop      = 4'($countones(in_data ^ exp_q));
   assign bit_base = clr_cnt ? '0 : bit_err_count;
   assign bit_sum  = {1'b0, bit_base} + {{(CNT_W-3){1'b0}}, pop};
   // saturating count of mismatched bits on counted errors
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) bit_err_count <= '0;
      else bit_err_count <= miss ? (bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0]) : bit_base;
   end
`else
   assign bit_err_count = '0;
`endif
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: randomized model-checked bench for lfsr_checker
module tb_lfsr_checker;
   localparam int LOCK = 4, LOSS = 3, CW = 16;
   localparam int MAX = (1 << CW) - 1;
   logic clk = 0, reset_n = 0, in_valid = 0, clr_cnt = 0;
   logic [7:0] in_data = 0;
   logic locked, err, lost;
   logic [CW-1:0] err_count, bit_err_count;
   int n_cmp = 0, n_bad = 0;
   bit m_lk, m_seed, m_locked, m_err, m_lost;
   logic [7:0] m_exp, w;
   int m_match, m_miss, m_ecnt, m_bcnt;

   lfsr_checker #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
      .clr_cnt(clr_cnt), .locked(locked), .err(err), .lost(lost),
      .err_count(err_count), .bit_err_count(bit_err_count));

   always #5 clk = ~clk;

   function automatic logic [7:0] nxt(input logic [7:0] s);
      return {s[6:0], s[0] ^ s[3] ^ s[5] ^ s[6]};
   endfunction
   function automatic int sat(input int x);
      return x > MAX ? MAX : x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
      end
   endtask

   task automatic model_reset();
      m_lk = 0; m_seed = 0; m_locked = 0; m_err = 0; m_lost = 0;
      m_exp = 0; m_match = 0; m_miss = 0; m_ecnt = 0; m_bcnt = 0;
   endtask

   task automatic model_step(input logic v, input logic [7:0] d, input logic c);
      logic [7:0] e;
      m_err = 0; m_lost = 0;
      if (c) begin m_ecnt = 0; m_bcnt = 0; end
      if (v) begin
         if (m_lk) begin
            e = m_exp;
            m_exp = nxt(m_exp);
            if (d != e) begin
               m_err = 1;
               m_ecnt = sat(m_ecnt + 1);
               m_bcnt = sat(m_bcnt + $countones(d ^ e));
               m_miss++;
               if (m_miss == LOSS) begin m_lk = 0; m_seed = 0; m_lost = 1; end
            end else m_miss = 0;
         end else if (m_seed && d == m_exp) begin
            m_match++;
            m_exp = nxt(d);
            if (m_match == LOCK) begin m_lk = 1; m_miss = 0; end
         end else begin
            m_seed = d != 0;
            if (d != 0) m_exp = nxt(d);
            m_match = 0;
         end
      end
      m_locked = m_lk;
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_n) model_step(in_valid, in_data, clr_cnt);
      #1;
   endtask

   task automatic put(input logic v, input logic [7:0] d, input logic c);
      in_valid = v; in_data = d; clr_cnt = c;
      tick();
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         chk("locked", locked, m_locked);
         chk("err", err, m_err);
         chk("lost", lost, m_lost);
         chk("err_count", err_count, m_ecnt);
`ifdef LFSR_CHK_BITERR_EN
         chk("bit_err_count", bit_err_count, m_bcnt);
`else
         chk("bit_err_count", bit_err_count, 0);
`endif
      end
   end

   initial begin
      logic v, c;
      logic [7:0] d;
      int r;
      model_reset();
      chk("nxt_8A", nxt(8'h8A), 8'h15);
      chk("nxt_2B", nxt(8'h2B), 8'h57);
      chk("nxt_57", nxt(8'h57), 8'hAE);
      repeat (3) tick();
      chk("rst_locked", locked, 0);
      chk("rst_err", err, 0);
      chk("rst_lost", lost, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_bit_count", bit_err_count, 0);
      reset_n = 1;
      repeat (10) put(1, 8'h00, 0);
      chk("zeros_no_lock", locked, 0);
      w = 8'h8A;
      repeat (4) begin put(1, w, 0); w = nxt(w); end
      chk("lock_before_AE", locked, 0);
      put(1, w, 0); w = nxt(w);
      chk("lock_after_AE", locked, 1);
      repeat (256) begin put(1, w, 0); w = nxt(w); end
      chk("soak_err_count", err_count, 0);
`ifdef LFSR_CHK_BITERR_EN
      put(1, w ^ 8'h03, 0); w = nxt(w);
      chk("single_bit_count", bit_err_count, 2);
`else
      put(1, w ^ 8'h01, 0); w = nxt(w);
`endif
      chk("single_err", err, 1);
      chk("single_count", err_count, 1);
      chk("single_locked", locked, 1);
      put(1, w, 0); w = nxt(w);
      chk("single_after", err, 0);
      repeat (2) begin put(1, w ^ 8'h80, 0); w = nxt(w); end
      chk("loss_still_locked", locked, 1);
      put(1, w ^ 8'h80, 0); w = nxt(w);
      chk("loss_lost", lost, 1);
      chk("loss_locked", locked, 0);
      chk("loss_count", err_count, 4);
      repeat (4) begin put(1, w, 0); w = nxt(w); end
      chk("relock_early", locked, 0);
      put(1, w, 0); w = nxt(w);
      chk("relock", locked, 1);
      chk("relock_count", err_count, 4);
      repeat (200) begin
         v = 1'($urandom_range(0, 1));
         put(v, v ? w : 8'($urandom), 0);
         if (v) w = nxt(w);
      end
      chk("stall_locked", locked, 1);
      chk("stall_count", err_count, 4);
      put(1, w ^ 8'h01, 1); w = nxt(w);
      chk("clr_and_err", err_count, 1);
      repeat (2000) begin
         v = $urandom_range(0, 3) != 0;
         r = $urandom_range(0, 31);
         d = r == 0 ? w ^ 8'($urandom_range(1, 255)) : r == 1 ? 8'($urandom) : w;
         c = $urandom_range(0, 63) == 0;
         put(v, d, c);
         if (v) w = nxt(w);
      end
      repeat (8) begin put(1, w, 0); w = nxt(w); end
      chk("final_relock", locked, 1);
      put(0, 0, 1);
      repeat (5) begin
         put(1, w ^ 8'h10, 0); w = nxt(w);
         put(1, w, 0); w = nxt(w);
      end
      chk("five_errs", err_count, 5);
      chk("five_locked", locked, 1);
      put(0, 0, 0);
      #1 reset_n = 0;
      model_reset();
      #1;
      chk("async_locked", locked, 0);
      chk("async_count", err_count, 0);
      chk("async_bits", bit_err_count, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side checker for the 8-bit Fibonacci LFSR pattern stream produced by the `lfsr` generator.
- Sits on the capture end of a link or loopback path and self-synchronises to the incoming words.
- Declares lock once the stream follows the polynomial, then counts words that deviate from the locally predicted sequence.
- Used for link bring-up and BER-style soak tests.

Parameters:
- LOCK_COUNT, 4: consecutive predicted matches after a seed word required to declare lock (1..15).
- LOSS_COUNT, 3: consecutive mismatches while locked that force loss of lock (1..15).
- CNT_W, 16: width of the error counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data is sampled this cycle; low means stall, no state advances.
- in_data  in  8  received LFSR word.
- clr_cnt  in  1  synchronous clear of the error counters.
- locked  out  1  checker is synchronised to the stream.
- err  out  1  one-cycle pulse: the word sampled last cycle mismatched while locked.
- lost  out  1  one-cycle pulse: lock dropped.
- err_count  out  CNT_W  saturating count of mismatched words.
- bit_err_count  out  CNT_W  saturating count of mismatched bits (see Optional Feature).

Behaviour:
- Next-state function: next(s) = {s[6:0], s[0]^s[3]^s[5]^s[6]}. Reference sequence: 8A, 15, 2B, 57, AE, ...
- Reset (async, reset_n=0): all outputs 0; FSM in HUNT; expected register 0; match and miss counters 0.
- All outputs are registered and reflect the word sampled on the previous clk edge (1-cycle latency).
- State HUNT, no seed held:
  - valid word != 00: exp <= next(word), match_cnt <= 0, seed held.
  - 00 is the lock-up state of the LFSR: always ignored and never seeds.
- State HUNT, seed held:
  - word == exp: match_cnt++, exp <= next(word).
  - match_cnt reaches LOCK_COUNT: go to LOCKED; locked=1 next cycle.
  - mismatch: reseed from the word (or drop the seed if the word is 00); match_cnt <= 0.
  - No err pulse and no counting in HUNT.
- State LOCKED:
  - Each valid word is compared to exp, then exp <= next(exp). The prediction is never reloaded from the data, so one bad word produces exactly one error.
  - Mismatch: err=1 for one cycle, err_count +1 (saturating at all-ones), miss_cnt++.
  - Match: miss_cnt <= 0.
  - miss_cnt reaches LOSS_COUNT: go to HUNT with no seed held; locked=0 and lost=1 on the same cycle as the final err pulse.
- in_valid=0: FSM, exp and all counters hold. err and lost are 0.
- clr_cnt: counters <= 0. If a mismatch is counted in the same cycle, clear is applied first, then the increment, giving a result of 1.
- Counters are not cleared by loss or reacquisition of lock; only reset_n or clr_cnt clears them.
- Reset asserted mid-operation: outputs go to 0 immediately, without waiting for a clock edge.

Optional Feature:
- Macro: LFSR_CHK_BITERR_EN.
- Defined: on every counted mismatch, bit_err_count increments by popcount(in_data ^ exp), range 1..8, saturating at all-ones. Cleared with err_count by clr_cnt and reset.
- Undefined: bit_err_count is tied to 0 and no popcount logic is built. All other behaviour is identical.

Test Plan:
- Lock and soak: reset, then stream 8A,15,2B,57,AE,... with in_valid=1 every cycle -> locked=1 one cycle after AE is sampled; 256 further words give err=0 throughout and err_count=0.
- Zero rejection: stream 00 for 10 cycles, then the 8A sequence -> locked stays 0 during the zeros; lock then follows the normal seed+4 timing.
- Single error: once locked, replace 57 with 56 -> one err pulse, err_count=1, locked stays 1, following words match. With LFSR_CHK_BITERR_EN, replace 57 with 54 -> bit_err_count=2.
- Loss and relock:
  - Once locked, corrupt 3 consecutive words -> err_count=3; locked falls and lost pulses on the third.
  - Resume a good stream -> relock after a seed plus 4 matches; err_count stays 3.
- Stalls and clear:
  - Random in_valid gaps in a good locked stream -> no err pulses, locked held.
  - clr_cnt pulsed in the same cycle as a counted error -> err_count=1.
- Async reset while locked with err_count=5: drop reset_n between clock edges -> locked=0 and err_count=0 before the next edge.
